if_layer_scheduler: RTL and testbench
=====================================

# if_layer_scheduler

Sequences one shared combinational integrate-and-fire datapath (signed 8x8 multiply plus 16-bit accumulate/add) across a layer of neurons. For each timestep it fetches activations and weights, drives MAC operations, then runs a threshold-and-fire pass per neuron. Membrane voltages live in an internal register file and persist across timesteps. It emits one spike pulse per firing neuron. It sits between the activation/weight memories and the spike output FIFO of each ensemble layer.

## Interface
- N_IN, 4: inputs per neuron (≥2)
- N_NEURON, 2: neurons per layer (≥2)
- THRESH, 16'sd100: signed 16-bit firing threshold (>0)

- clk  in  1  clock; all state on rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- start  in  1  begin one timestep; sampled only in IDLE
- clear_vol  in  1  zero all membrane voltages; honoured only in IDLE, same cycle as or without start (clear applies first)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in DONE
- act_addr  out  clog2(N_IN)  activation read address
- act_data  in  8 signed  activation, valid one cycle after act_addr
- w_addr  out  clog2(N_IN*N_NEURON)  weight address = n*N_IN + i
- w_data  in  8 signed  weight, valid one cycle after w_addr
- dp_activation, dp_weight  out  8 signed each  datapath operands
- dp_pre_vol  out  16 signed  datapath accumulated-voltage input
- dp_diff  out  16 signed  datapath add operand
- dp_arithm  out  1  0 = MAC, 1 = add
- dp_post_vol  in  16 signed  datapath result
- dp_of_flag  in  1  datapath carry flag
- spike_valid  out  1  one-cycle spike pulse
- spike_idx  out  clog2(N_NEURON)  index of the firing neuron
- ovf  out  1  sticky; cleared on start, set if any MAC in the timestep overflowed
- vol_rd_idx  in  clog2(N_NEURON)  debug read select
- vol_rd_data  out  16 signed  combinational read of vol[vol_rd_idx]

## Operation
- States: IDLE, FETCH, MAC, FIRE, DONE. Counters: n (neuron), i (input).
- IDLE: when start=1, go to FETCH with n=0, i=0, ovf=0.
- FETCH: act_addr=i, w_addr=n*N_IN+i (registered from the counters). Go to MAC.
- MAC: dp_arithm=0, dp_activation=act_data, dp_weight=w_data, dp_pre_vol=vol[n]; vol[n] <= dp_post_vol.
  - Next state is FIRE if i==N_IN-1. Otherwise increment i and return to FETCH.
- FIRE: dp_arithm=1, dp_pre_vol=vol[n], dp_diff=-THRESH.
  - If vol[n] >= THRESH (signed): vol[n] <= dp_post_vol (reset by subtraction), and spike_valid/spike_idx=n are registered for the next cycle.
  - Next state is DONE if n==N_NEURON-1. Otherwise increment n, set i=0, and return to FETCH.
- DONE: done=1, then IDLE.
- Overflow is true signed overflow: the addends have the same sign and the result sign differs. The controller computes it internally, and it sets ovf. dp_of_flag is ignored for this purpose.
- Outside MAC/FIRE, the dp_* outputs are 0 and dp_arithm=0.
- start while busy is ignored. clear_vol while busy is ignored.

## Timing
- Reset values: state IDLE, all vol=0, n=i=0; every output 0.
- rst mid-timestep aborts the timestep: no done, no further spikes, voltages cleared.
- Cycles per neuron: 2*N_IN+1. If start is sampled in cycle 0, done is high in cycle 1+N_NEURON*(2*N_IN+1), and busy falls the cycle after.
- A spike pulse appears in the cycle after that neuron's FIRE state. It never coincides with another spike.
- Back-to-back: start may be asserted in the first IDLE cycle after DONE.

## Configuration
- IF_SCHED_SAT_EN
  - Defined: on MAC overflow, vol[n] is written 16'sh7FFF (positive overflow) or 16'sh8000 (negative overflow), and ovf is set.
  - Undefined: vol[n] takes the wrapped dp_post_vol, and ovf is still set.
- FIRE never overflows because THRESH>0 and vol≥THRESH.

## Test plan
- Defaults, all acts=10, neuron0 weights=3, neuron1 weights=-5, start at cycle 0 -> done at cycle 19; one spike idx=0 at cycle 10; vol0=20, vol1=-200; ovf=0.
- Repeat the same timestep without clear_vol -> vol0 140→spike→40, vol1=-400; second run then clear_vol+start -> both start from 0.
- All acts=127, weights=127, macro defined -> vol0=32767, ovf=1, spike idx0, vol0=32667.
- Same stimulus, macro undefined -> vol0=-1020 after MAC, no spike, ovf=1.
- start pulsed at cycle 5 and clear_vol at cycle 7 while busy -> ignored; single done at cycle 19; voltages unaffected.
- rst asserted at cycle 8 -> next cycle busy=0 and all vol=0; no spike or done; a fresh start behaves as in scenario 1.

Source files
------------

// File: rtl/if_layer_scheduler.sv
// Time-multiplexed integrate-and-fire scheduler driving one shared MAC/add datapath.
// Optional IF_SCHED_SAT_EN: clamp membrane voltage on MAC overflow instead of wrapping.
module if_layer_scheduler #(
    parameter int                 N_IN     = 4,
    parameter int                 N_NEURON = 2,
    parameter logic signed [15:0] THRESH   = 16'sd100
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   clear_vol,
    output logic                                   busy,
    output logic                                   done,
    output logic [$clog2(N_IN)-1:0]                act_addr,
    input  logic signed [7:0]                      act_data,
    output logic [$clog2(N_IN*N_NEURON)-1:0]       w_addr,
    input  logic signed [7:0]                      w_data,
    output logic signed [7:0]                      dp_activation,
    output logic signed [7:0]                      dp_weight,
    output logic signed [15:0]                     dp_pre_vol,
    output logic signed [15:0]                     dp_diff,
    output logic                                   dp_arithm,
    input  logic signed [15:0]                     dp_post_vol,
    input  logic                                   dp_of_flag,
    output logic                                   spike_valid,
    output logic [$clog2(N_NEURON)-1:0]            spike_idx,
    output logic                                   ovf,
    input  logic [$clog2(N_NEURON)-1:0]            vol_rd_idx,
    output logic signed [15:0]                     vol_rd_data
);
    localparam int IN_W = $clog2(N_IN);
    localparam int NR_W = $clog2(N_NEURON);
    localparam int AW   = $clog2(N_IN * N_NEURON);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_MAC, S_FIRE, S_DONE} state_t;

    state_t             state_reg, state_next;
    logic [IN_W-1:0]    i_reg, i_next;
    logic [NR_W-1:0]    n_reg, n_next;
    logic signed [15:0] vol_reg [N_NEURON];
    logic               ovf_reg;
    logic               spike_valid_reg;
    logic [NR_W-1:0]    spike_idx_reg;

    logic signed [15:0] cur_vol;
    logic signed [15:0] product;
    logic               mac_ovf;
    logic               vol_we;
    logic signed [15:0] vol_wdata;
    logic               fire_ok;
    logic               clear_all;
    logic               start_go;
    logic               unused_of_flag;

    // The datapath's own carry flag is not a signed-overflow indicator.
    assign unused_of_flag = dp_of_flag;

    assign cur_vol     = vol_reg[n_reg];
    assign product     = 16'(act_data) * 16'(w_data);
    assign mac_ovf     = (product[15] == cur_vol[15]) && (dp_post_vol[15] != cur_vol[15]);
    assign act_addr    = i_reg;
    assign w_addr      = AW'(n_reg) * AW'(N_IN) + AW'(i_reg);
    assign ovf         = ovf_reg;
    assign spike_valid = spike_valid_reg;
    assign spike_idx   = spike_idx_reg;
    assign vol_rd_data = vol_reg[vol_rd_idx];

    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next    = state_reg;
        i_next        = i_reg;
        n_next        = n_reg;
        busy          = 1'b1;
        done          = 1'b0;
        dp_activation = '0;
        dp_weight     = '0;
        dp_pre_vol    = '0;
        dp_diff       = '0;
        dp_arithm     = 1'b0;
        vol_we        = 1'b0;
        vol_wdata     = dp_post_vol;
        fire_ok       = 1'b0;
        clear_all     = 1'b0;
        start_go      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                busy      = 1'b0;
                clear_all = clear_vol;
                if (start) begin
                    start_go   = 1'b1;
                    state_next = S_FETCH;
                    i_next     = '0;
                    n_next     = '0;
                end
            end
            S_FETCH: state_next = S_MAC;
            S_MAC: begin
                dp_activation = act_data;
                dp_weight     = w_data;
                dp_pre_vol    = cur_vol;
                vol_we        = 1'b1;
`ifdef IF_SCHED_SAT_EN
                if (mac_ovf) vol_wdata = cur_vol[15] ? 16'sh8000 : 16'sh7FFF;
`endif
                if (i_reg == IN_W'(N_IN - 1)) begin
                    state_next = S_FIRE;
                end else begin
                    i_next     = i_reg + IN_W'(1);
                    state_next = S_FETCH;
                end
            end
            S_FIRE: begin
                dp_arithm  = 1'b1;
                dp_pre_vol = cur_vol;
                dp_diff    = -THRESH;
                fire_ok    = (cur_vol >= THRESH);
                vol_we     = fire_ok;
                i_next     = '0;
                if (n_reg == NR_W'(N_NEURON - 1)) begin
                    n_next     = '0;
                    state_next = S_DONE;
                end else begin
                    n_next     = n_reg + NR_W'(1);
                    state_next = S_FETCH;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_reg           <= '0;
            n_reg           <= '0;
            ovf_reg         <= 1'b0;
            spike_valid_reg <= 1'b0;
            spike_idx_reg   <= '0;
        end else begin
            i_reg           <= i_next;
            n_reg           <= n_next;
            spike_valid_reg <= fire_ok;
            spike_idx_reg   <= fire_ok ? n_reg : '0;
            if (start_go)
                ovf_reg <= 1'b0;
            else if (state_reg == S_MAC && mac_ovf)
                ovf_reg <= 1'b1;
        end
    end

    // Membrane voltage file: cleared by reset or an idle clear, written by MAC/FIRE.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N_NEURON; k++) begin
            if (rst || clear_all)
                vol_reg[k] <= '0;
            else if (vol_we && n_reg == NR_W'(k))
                vol_reg[k] <= vol_wdata;
        end
    end
endmodule

// File: tb/tb_if_layer_scheduler.sv
// Directed bench for if_layer_scheduler: memories and datapath modelled around the DUT.
module tb_if_layer_scheduler;
    logic               clk = 1'b0;
    logic               rst, start, clear_vol;
    logic               busy, done;
    logic [1:0]         act_addr;
    logic signed [7:0]  act_data;
    logic [2:0]         w_addr;
    logic signed [7:0]  w_data;
    logic signed [7:0]  dp_activation, dp_weight;
    logic signed [15:0] dp_pre_vol, dp_diff, dp_post_vol;
    logic               dp_arithm, dp_of_flag;
    logic               spike_valid;
    logic [0:0]         spike_idx;
    logic               ovf;
    logic [0:0]         vol_rd_idx;
    logic signed [15:0] vol_rd_data;

    logic signed [7:0]  act_mem [4];
    logic signed [7:0]  w_mem [8];
    logic signed [31:0] dp_a, dp_b, dp_s;

    int n_checks = 0;
    int n_pass   = 0;

    if_layer_scheduler #(.N_IN(4), .N_NEURON(2), .THRESH(16'sd100)) dut (
        .clk(clk), .rst(rst), .start(start), .clear_vol(clear_vol),
        .busy(busy), .done(done),
        .act_addr(act_addr), .act_data(act_data),
        .w_addr(w_addr), .w_data(w_data),
        .dp_activation(dp_activation), .dp_weight(dp_weight),
        .dp_pre_vol(dp_pre_vol), .dp_diff(dp_diff), .dp_arithm(dp_arithm),
        .dp_post_vol(dp_post_vol), .dp_of_flag(dp_of_flag),
        .spike_valid(spike_valid), .spike_idx(spike_idx), .ovf(ovf),
        .vol_rd_idx(vol_rd_idx), .vol_rd_data(vol_rd_data)
    );

    always #5 clk = ~clk;

    // Synchronous-read activation and weight memories.
    always @(posedge clk) begin
        act_data <= act_mem[act_addr];
        w_data   <= w_mem[w_addr];
    end

    // Shared combinational datapath.
    always_comb begin
        dp_a        = 32'(dp_pre_vol);
        dp_b        = dp_arithm ? 32'(dp_diff) : 32'(dp_activation) * 32'(dp_weight);
        dp_s        = dp_a + dp_b;
        dp_post_vol = dp_s[15:0];
        dp_of_flag  = (dp_s > 32767) || (dp_s < -32768);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic read_vol(input int idx, output int val);
        vol_rd_idx = 1'(idx);
        #1;
        val = int'(vol_rd_data);
    endtask

    task automatic load_mem(input int a, input int w0, input int w1);
        for (int k = 0; k < 4; k++) begin
            act_mem[k]   = 8'(a);
            w_mem[k]     = 8'(w0);
            w_mem[k + 4] = 8'(w1);
        end
    endtask

    // One timestep, cycle 0 = the cycle start is sampled. kind: 0 plain, 1 start/clear while busy, 2 reset mid-run.
    task automatic run_ts(input string name, input logic clr, input int kind,
                          output int done_n, output int done_cyc, output int spk_n,
                          output int spk_cyc0, output int spk_idx0,
                          output int spk_cyc1, output int spk_idx1, output int busy_fall);
        int v;
        done_n = 0; done_cyc = -1; spk_n = 0; busy_fall = -1;
        spk_cyc0 = -1; spk_idx0 = -1; spk_cyc1 = -1; spk_idx1 = -1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (done) begin done_n++; done_cyc = k; end
            if (spike_valid) begin
                if (spk_n == 0) begin spk_cyc0 = k; spk_idx0 = int'(spike_idx); end
                else begin spk_cyc1 = k; spk_idx1 = int'(spike_idx); end
                spk_n++;
            end
            if (k > 0 && !busy && busy_fall < 0) busy_fall = k;
            if (kind == 2 && k == 9) begin
                check({name, "_busy_after_rst"}, int'(busy), 0);
                read_vol(0, v); check({name, "_vol0_after_rst"}, v, 0);
                read_vol(1, v); check({name, "_vol1_after_rst"}, v, 0);
            end
            start     = (k == 0) || (kind == 1 && k == 5);
            clear_vol = (k == 0 && clr) || (kind == 1 && k == 7);
            rst       = (kind == 2 && k == 8);
        end
        $display("%s: done_n=%0d done_cyc=%0d spikes=%0d busy_fall=%0d", name, done_n, done_cyc, spk_n, busy_fall);
    endtask

    initial begin
        int dn, dc, sn, sc0, si0, sc1, si1, bf, v;
        rst = 1'b1; start = 1'b0; clear_vol = 1'b0; vol_rd_idx = '0;
        load_mem(10, 3, -5);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_spike", int'(spike_valid), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_w_addr", int'(w_addr), 0);
        check("rst_dp_pre_vol", int'(dp_pre_vol), 0);
        read_vol(0, v); check("rst_vol0", v, 0);
        read_vol(1, v); check("rst_vol1", v, 0);
        $display("reset: busy=%0d ovf=%0d", busy, ovf);

        run_ts("ts1", 1'b1, 0, dn, dc, sn, sc0, si0, sc1, si1, bf);
        check("ts1_done_n", dn, 1);
        check("ts1_done_cyc", dc, 19);
        check("ts1_busy_fall", bf, 20);
        check("ts1_spk_n", sn, 1);
        check("ts1_spk_cyc", sc0, 10);
        check("ts1_spk_idx", si0, 0);
        read_vol(0, v); check("ts1_vol0", v, 20);
        read_vol(1, v); check("ts1_vol1", v, -200);
        check("ts1_ovf", int'(ovf), 0);

        run_ts("ts2", 1'b0, 0, dn, dc, sn, sc0, si0, sc1, si1, bf);
        check("ts2_spk_n", sn, 1);
        check("ts2_spk_cyc", sc0, 10);
        read_vol(0, v); check("ts2_vol0", v, 40);
        read_vol(1, v); check("ts2_vol1", v, -400);

        run_ts("ts3_clear", 1'b1, 0, dn, dc, sn, sc0, si0, sc1, si1, bf);
        read_vol(0, v); check("ts3_vol0", v, 20);
        read_vol(1, v); check("ts3_vol1", v, -200);

        run_ts("ts4_busy_ignore", 1'b0, 1, dn, dc, sn, sc0, si0, sc1, si1, bf);
        check("ts4_done_n", dn, 1);
        check("ts4_done_cyc", dc, 19);
        check("ts4_busy_fall", bf, 20);
        check("ts4_spk_n", sn, 1);
        read_vol(0, v); check("ts4_vol0", v, 40);
        read_vol(1, v); check("ts4_vol1", v, -400);

        run_ts("ts5_rst", 1'b0, 2, dn, dc, sn, sc0, si0, sc1, si1, bf);
        check("ts5_done_n", dn, 0);
        check("ts5_spk_n", sn, 0);
        check("ts5_busy_fall", bf, 9);

        run_ts("ts6_fresh", 1'b0, 0, dn, dc, sn, sc0, si0, sc1, si1, bf);
        check("ts6_done_cyc", dc, 19);
        check("ts6_spk_cyc", sc0, 10);
        check("ts6_spk_idx", si0, 0);
        read_vol(0, v); check("ts6_vol0", v, 20);
        read_vol(1, v); check("ts6_vol1", v, -200);

        load_mem(127, 127, 127);
        run_ts("ts7_ovf", 1'b1, 0, dn, dc, sn, sc0, si0, sc1, si1, bf);
        check("ts7_ovf", int'(ovf), 1);
        check("ts7_done_cyc", dc, 19);
`ifdef IF_SCHED_SAT_EN
        check("ts7_spk_n", sn, 2);
        check("ts7_spk_cyc0", sc0, 10);
        check("ts7_spk_idx0", si0, 0);
        check("ts7_spk_cyc1", sc1, 19);
        check("ts7_spk_idx1", si1, 1);
        read_vol(0, v); check("ts7_vol0", v, 32667);
        read_vol(1, v); check("ts7_vol1", v, 32667);
`else
        check("ts7_spk_n", sn, 0);
        read_vol(0, v); check("ts7_vol0", v, -1020);
        read_vol(1, v); check("ts7_vol1", v, -1020);
`endif

        load_mem(10, 3, -5);
        run_ts("ts8_ovf_clear", 1'b1, 0, dn, dc, sn, sc0, si0, sc1, si1, bf);
        check("ts8_ovf", int'(ovf), 0);
        read_vol(0, v); check("ts8_vol0", v, 20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
